// File: rtl/piano_pkg.sv
// Shared constants, note table and state encoding for the tone mixer and its oscillators.
package piano_pkg;

    localparam int NUM_NOTES = 24;
    localparam int LEVEL_MAX = 255;
    localparam int HALF_W    = 18;
    localparam int LEVEL_W   = 8;
    localparam int ACC_W     = 48;
    localparam int SAMPLE_W  = 32;

    // Half-period in 50 MHz cycles, C3 (index 0) up to B4 (index 23).
    localparam logic [HALF_W-1:0] HALF_PERIOD [NUM_NOTES] = '{
        18'd190080, 18'd180129, 18'd170068, 18'd160458, 18'd151515, 18'd143003,
        18'd135135, 18'd127551, 18'd120481, 18'd113636, 18'd107290, 18'd101214,
        18'd95238,  18'd90177,  18'd85470,  18'd80290,  18'd75758,  18'd71644,
        18'd67567,  18'd63723,  18'd60240,  18'd56818,  18'd53598,  18'd50584
    };

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_SAT   = 2'd1,
        ST_VALID = 2'd2
    } mix_state_t;

    // One envelope step: saturating ramp up while held, down to zero once released.
    function automatic logic [LEVEL_W-1:0] env_next(
        input logic [LEVEL_W-1:0] lvl,
        input logic               key,
        input logic [LEVEL_W-1:0] up,
        input logic [LEVEL_W-1:0] down
    );
        logic [LEVEL_W:0] sum;
        sum = {1'b0, lvl} + {1'b0, up};
        if (key) begin
            return (sum > (LEVEL_W+1)'(LEVEL_MAX)) ? LEVEL_W'(LEVEL_MAX) : sum[LEVEL_W-1:0];
        end
        return (lvl > down) ? (lvl - down) : '0;
    endfunction

endpackage

// File: rtl/tone_osc.sv
// Free-running square-wave oscillator with a period of 2*(half_period+1) clock cycles.
module tone_osc
    import piano_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic [HALF_W-1:0] half_period,
    output logic              tone
);

    logic [HALF_W-1:0] count;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            tone  <= 1'b0;
        end else if (count == half_period) begin
            count <= '0;
            tone  <= ~tone;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tone_mixer.sv
// Polyphonic square-wave source: per-note attack/release envelopes, serial mix into a
// saturated 32-bit sample offered on a valid/ready handshake.
module tone_mixer
    import piano_pkg::*;
#(
    parameter int NUM_NOTES    = 24,
    parameter int AMP_UNIT     = 196078,
    parameter int ATTACK_STEP  = 8,
    parameter int RELEASE_STEP = 2
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic [NUM_NOTES-1:0] note_on,
    input  logic                 sample_ready,
    output logic [SAMPLE_W-1:0]  sample_out,
    output logic                 sample_valid,
    output logic                 active
);

    localparam int IDX_W = $clog2(NUM_NOTES);
    localparam logic [IDX_W-1:0]         IDX_LAST  = IDX_W'(NUM_NOTES - 1);
    localparam logic signed [ACC_W-1:0]  AMP_S     = ACC_W'(AMP_UNIT);
    localparam logic [LEVEL_W-1:0]       ATTACK_8  = LEVEL_W'(ATTACK_STEP);
    localparam logic [LEVEL_W-1:0]       RELEASE_8 = LEVEL_W'(RELEASE_STEP);
    localparam logic signed [ACC_W-1:0]  SAT_HI    = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  SAT_LO    = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    function automatic logic signed [SAMPLE_W-1:0] sat32(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI) return SAT_HI[SAMPLE_W-1:0];
        if (v < SAT_LO) return SAT_LO[SAMPLE_W-1:0];
        return v[SAMPLE_W-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] note_term(
        input logic [LEVEL_W-1:0] lvl,
        input logic               tn
    );
        logic signed [ACC_W-1:0] mag;
        mag = $signed({{(ACC_W-LEVEL_W){1'b0}}, lvl}) * AMP_S;
        return tn ? mag : -mag;
    endfunction

    logic [NUM_NOTES-1:0]    note_meta;
    logic [NUM_NOTES-1:0]    note_s;
    logic [NUM_NOTES-1:0]    tone;
    logic [LEVEL_W-1:0]      level   [NUM_NOTES];
    logic [LEVEL_W-1:0]      level_d [NUM_NOTES];
    logic                    any_level;
    logic                    accept;
    mix_state_t              state;
    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] term;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            note_meta <= '0;
            note_s    <= '0;
        end else begin
            note_meta <= note_on;
            note_s    <= note_meta;
        end
    end

    for (genvar i = 0; i < NUM_NOTES; i++) begin : g_osc
        tone_osc u_osc (
            .CLOCK_50    (CLOCK_50),
            .reset_n     (reset_n),
            .half_period (HALF_PERIOD[i]),
            .tone        (tone[i])
        );
    end

    assign accept = sample_valid && sample_ready;

    // Envelopes only move on an accept edge, so back-pressure freezes them.
    always_comb begin
        any_level = 1'b0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            level_d[i] = accept ? env_next(level[i], note_s[i], ATTACK_8, RELEASE_8) : level[i];
            any_level  = any_level | (level_d[i] != '0);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_NOTES; i++) begin
                level[i] <= '0;
            end
            active <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_NOTES; i++) begin
                level[i] <= level_d[i];
            end
            active <= any_level;
        end
    end

    assign term = note_term(level[idx], tone[idx]);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_ACCUM;
            idx          <= '0;
            acc          <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    acc <= acc + term;
                    if (idx == IDX_LAST) begin
                        idx   <= '0;
                        state <= ST_SAT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_SAT: begin
                    sample_out   <= sat32(acc);
                    sample_valid <= 1'b1;
                    state        <= ST_VALID;
                end
                ST_VALID: begin
                    if (sample_ready) begin
                        sample_valid <= 1'b0;
                        acc          <= '0;
                        idx          <= '0;
                        state        <= ST_ACCUM;
                    end
                end
                default: begin
                    state <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule
